systolic_seq_ctrl: RTL and testbench

Sequencer for a SIZE x SIZE systolic array of shift-accumulate MAC cells. Each cell takes an 8-bit left operand and an 8-bit up shift code. On start, the block clears the array and streams k_len operand vectors from two operand buffers into the array edges with diagonal skew. It then waits for the wavefront to flush and drains the accumulated results one row at a time over a valid/ready port. It sits between the operand SRAMs and the array, and between the array and the result writer.

---
 rtl/systolic_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencer for a SIZE x SIZE shift-accumulate systolic array.
// Clears the array, streams k_len skewed operand vectors from the operand buffers
// into the array edges, waits for the wavefront to flush, then drains one row per
// valid/ready transfer.
// Ports: clk/reset_n (async active-low); start/k_len job request; busy/done status;
// a_rd_*/w_rd_* operand buffer reads (1-cycle latency); arr_clr/arr_left/arr_up
// drive the array; arr_mat holds the accumulators; out_valid/out_ready/out_row/
// out_idx form the result port.
module systolic_seq_ctrl #(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    a_rd_en,
  output logic [ADDR_W-1:0]       a_rd_addr,
  input  logic [SIZE*8-1:0]       a_rd_data,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_rd_addr,
  input  logic [SIZE*8-1:0]       w_rd_data,
  output logic                    arr_clr,
  output logic [SIZE*8-1:0]       arr_left,
  output logic [SIZE*8-1:0]       arr_up,
  input  logic [SIZE*SIZE*8-1:0]  arr_mat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE*8-1:0]       out_row,
  output logic [$clog2(SIZE)-1:0] out_idx
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = (ADDR_W + 1 > 5) ? ADDR_W + 1 : 5;
  localparam logic [CW-1:0] KMAX = CW'(1) << ADDR_W;
  localparam logic [CW-1:0] FL_LAST = CW'(2 * SIZE - 1);
  localparam logic [IW-1:0] LAST_ROW = IW'(SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE
  } state_t;

  state_t state, state_d;
  logic [CW-1:0] k_q, k_sat, cnt;
  logic clr_q, rd_vld, xfer;
  logic [IW-1:0] row_sel;
  logic [SIZE*8-1:0] row_bus, a_in, w_in;

  assign k_sat = (CW'(k_len) > KMAX) ? KMAX : CW'(k_len);
  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = (k_q == '0) ? DRAIN : FEED;
      FEED:  if (cnt + 1'b1 == k_q) state_d = FLUSH;
      FLUSH: if (cnt == FL_LAST) state_d = DRAIN;
      DRAIN: if (xfer && out_idx == LAST_ROW) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      k_q    <= '0;
      cnt    <= '0;
      clr_q  <= 1'b1;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_d;
      clr_q  <= (state_d == CLEAR);
      rd_vld <= a_rd_en;
      if (state == IDLE && start) k_q <= k_sat;
      if (state_d != state) cnt <= '0;
      else if (state == FEED || state == FLUSH)
        cnt <= cnt + 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign arr_clr   = clr_q;
  assign a_rd_en   = (state == FEED);
  assign w_rd_en   = a_rd_en;
  assign a_rd_addr = a_rd_en ? cnt[ADDR_W-1:0] : '0;
  assign w_rd_addr = a_rd_addr;

  // Idle lanes carry zeros so the array adds 0 << 0 between vectors.
  assign a_in = rd_vld ? a_rd_data : '0;
  assign w_in = rd_vld ? w_rd_data : '0;
  assign arr_left[7:0] = a_in[7:0];
  assign arr_up[7:0]   = w_in[7:0];

  // Lane i is delayed by i registers to form the diagonal wavefront.
  for (genvar i = 1; i < SIZE; i++) begin : g_lane
    logic [7:0] a_d [i];
    logic [7:0] w_d [i];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < i; k++) begin
          a_d[k] <= '0;
          w_d[k] <= '0;
        end
      end else begin
        a_d[0] <= a_in[i*8 +: 8];
        w_d[0] <= w_in[i*8 +: 8];
        for (int k = 1; k < i; k++) begin
          a_d[k] <= a_d[k-1];
          w_d[k] <= w_d[k-1];
        end
      end
    end
    assign arr_left[i*8 +: 8] = a_d[i-1];
    assign arr_up[i*8 +: 8]   = w_d[i-1];
  end

  assign row_sel = (state == DRAIN) ? out_idx + 1'b1 : '0;

  always_comb begin
    row_bus = '0;
    for (int r = 0; r < SIZE; r++)
      if (row_sel == IW'(r))
        row_bus = arr_mat[r*SIZE*8 +: SIZE*8];
  end

  // With k_len=0 the clear and the first row load share one edge, so the
  // array still shows the previous job; force zeros instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_row   <= '0;
    end else if (state != DRAIN && state_d == DRAIN) begin
      out_valid <= 1'b1;
      out_idx   <= '0;
      out_row   <= (k_q == '0) ? '0 : row_bus;
    end else if (xfer) begin
      if (out_idx == LAST_ROW) begin
        out_valid <= 1'b0;
      end else begin
        out_idx <= out_idx + 1'b1;
        out_row <= (k_q == '0) ? '0 : row_bus;
      end
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: random and directed jobs for systolic_seq_ctrl.
// Includes operand buffers, a shift-accumulate array and a job-level reference.
module tb_systolic_seq_ctrl;
  localparam int SIZE = 4;
  localparam int ADDR_W = 8;
  localparam int VW = SIZE * 8;
  localparam int IW = $clog2(SIZE);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W:0] k_len = '0;
  logic out_ready = 1'b1;
  logic busy, done, a_rd_en, w_rd_en, arr_clr, out_valid;
  logic [ADDR_W-1:0] a_rd_addr, w_rd_addr;
  logic [VW-1:0] a_rd_data, w_rd_data, arr_left, arr_up, out_row;
  logic [SIZE*VW-1:0] arr_mat;
  logic [IW-1:0] out_idx;

  int checks = 0;
  int errors = 0;

  systolic_seq_ctrl #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .arr_clr(arr_clr), .arr_left(arr_left), .arr_up(arr_up),
    .arr_mat(arr_mat), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mac(input logic [7:0] a, input logic [7:0] w);
    logic [7:0] p;
    p = a << w;
    return p;
  endfunction

  // operand buffers, 1-cycle read latency, junk when not read
  logic [VW-1:0] a_mem [256];
  logic [VW-1:0] w_mem [256];

  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? a_mem[a_rd_addr] : VW'($urandom);
    w_rd_data <= w_rd_en ? w_mem[w_rd_addr] : VW'($urandom);
  end

  // the systolic array itself: left operands move right, shift codes down
  logic [7:0] acc [SIZE][SIZE];
  logic [7:0] hl [SIZE][SIZE];
  logic [7:0] vu [SIZE][SIZE];

  always @(posedge clk) begin
    logic [7:0] ia, iw;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        if (c == 0) ia = arr_left[r*8 +: 8];
        else ia = hl[r][c-1];
        if (r == 0) iw = arr_up[c*8 +: 8];
        else iw = vu[r-1][c];
        if (arr_clr) begin
          acc[r][c] <= '0;
          hl[r][c] <= '0;
          vu[r][c] <= '0;
        end else begin
          acc[r][c] <= acc[r][c] + mac(ia, iw);
          hl[r][c] <= ia;
          vu[r][c] <= iw;
        end
      end
  end

  always_comb begin
    arr_mat = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        arr_mat[(r*SIZE+c)*8 +: 8] = acc[r][c];
  end

  // consumer ready: 0 always, 1 random, 2 repeating 1,0,0,1
  int rdy_mode = 0;
  int pat = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else begin
      out_ready = (pat % 4 == 0) || (pat % 4 == 3);
      pat++;
    end
  end

  // job-level reference: cycle n counts from the accepted start cycle
  bit job = 0;
  bit post_rst = 1;
  int n, k_eff, drain_at, rows;
  int dut_dones = 0;
  int first_valid_n, first_rd_n, first_b3_n;
  logic [VW-1:0] exp_res [SIZE];
  logic [VW-1:0] rec_rows [$];
  int rec_idx [$];
  int rd_addrs [$];

  always @(negedge clk) begin
    logic [VW-1:0] el, eu;
    logic [7:0] s;
    int t;
    bit erd;
    if (!reset_n) begin
      job = 0;
      post_rst = 1;
    end else if (!job) begin
      chk("idle_clr", 64'(arr_clr), 64'(post_rst));
      post_rst = 0;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_rd", 64'({a_rd_en, w_rd_en}), 64'd0);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_left", 64'(arr_left), 64'd0);
      chk("idle_up", 64'(arr_up), 64'd0);
      if (start) begin
        job = 1;
        n = 1;
        k_eff = (k_len > 256) ? 256 : int'(k_len);
        drain_at = (k_eff > 0) ? k_eff + 2 + 2 * SIZE : 2;
        rows = 0;
        for (int r = 0; r < SIZE; r++)
          for (int c = 0; c < SIZE; c++) begin
            s = 0;
            for (int k = 0; k < k_eff; k++)
              s += mac(a_mem[k][r*8 +: 8], w_mem[k][c*8 +: 8]);
            exp_res[r][c*8 +: 8] = s;
          end
        rec_rows.delete();
        rec_idx.delete();
        rd_addrs.delete();
        first_valid_n = -1;
        first_rd_n = -1;
        first_b3_n = -1;
      end
    end else begin
      if (done) dut_dones++;
      erd = (n >= 2) && (n < 2 + k_eff);
      chk("busy", 64'(busy), 64'd1);
      chk("clr", 64'(arr_clr), 64'(n == 1));
      chk("a_rd_en", 64'(a_rd_en), 64'(erd));
      chk("w_rd_en", 64'(w_rd_en), 64'(erd));
      if (erd) begin
        chk("a_addr", 64'(a_rd_addr), 64'(n - 2));
        chk("w_addr", 64'(w_rd_addr), 64'(n - 2));
      end
      if (a_rd_en) begin
        rd_addrs.push_back(int'(a_rd_addr));
        if (first_rd_n < 0) first_rd_n = n;
      end
      el = '0;
      eu = '0;
      for (int i = 0; i < SIZE; i++) begin
        t = n - 3 - i;
        if (t >= 0 && t < k_eff) begin
          el[i*8 +: 8] = a_mem[t][i*8 +: 8];
          eu[i*8 +: 8] = w_mem[t][i*8 +: 8];
        end
      end
      chk("arr_left", 64'(arr_left), 64'(el));
      chk("arr_up", 64'(arr_up), 64'(eu));
      if (arr_left[VW-1 -: 8] != 0 && first_b3_n < 0) first_b3_n = n;
      if (out_valid && first_valid_n < 0) first_valid_n = n;
      if (n < drain_at) begin
        chk("early_valid", 64'(out_valid), 64'd0);
        chk("early_done", 64'(done), 64'd0);
      end else if (rows < SIZE) begin
        chk("valid", 64'(out_valid), 64'd1);
        chk("drain_done", 64'(done), 64'd0);
        chk("out_idx", 64'(out_idx), 64'(rows));
        chk("out_row", 64'(out_row), 64'(exp_res[rows]));
        if (out_ready) begin
          rec_rows.push_back(out_row);
          rec_idx.push_back(int'(out_idx));
          rows++;
        end
      end else begin
        chk("done", 64'(done), 64'd1);
        chk("end_valid", 64'(out_valid), 64'd0);
        job = 0;
      end
      n++;
    end
  end

  task automatic fill(input bit nz);
    for (int t = 0; t < 256; t++)
      for (int b = 0; b < SIZE; b++) begin
        a_mem[t][b*8 +: 8] = nz ? 8'($urandom_range(1, 255))
                                : 8'($urandom_range(0, 255));
        w_mem[t][b*8 +: 8] = 8'($urandom_range(0, 7));
      end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (done !== 1'b1 && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("done_seen", 64'(w < 3000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int k);
    @(posedge clk);
    #1;
    k_len = (ADDR_W+1)'(k);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int d0, kk;
    fill(1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clr", 64'(arr_clr), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd", 64'({a_rd_en, w_rd_en}), 64'd0);
    chk("rst_addr", 64'({a_rd_addr, w_rd_addr}), 64'd0);
    chk("rst_edges", 64'({arr_left, arr_up}), 64'd0);
    chk("rst_out", 64'({out_valid, out_idx, out_row}), 64'd0);
    reset_n = 1'b1;
    #3;
    chk("rel_clr_hold", 64'(arr_clr), 64'd1);
    @(posedge clk);
    #1;
    chk("rel_clr_drop", 64'(arr_clr), 64'd0);

    // single step: a=[3,5,0,0], w=[0,1,0,0]
    a_mem[0] = 32'h0000_0503;
    w_mem[0] = 32'h0000_0100;
    run_job(1);
    chk("k1_rows", 64'(rec_rows.size()), 64'd4);
    chk("k1_row0", 64'(rec_rows[0]), 64'h0303_0603);
    chk("k1_row1", 64'(rec_rows[1]), 64'h0505_0a05);
    chk("k1_row2", 64'(rec_rows[2]), 64'd0);
    chk("k1_row3", 64'(rec_rows[3]), 64'd0);

    // three steps: address order, lane-3 skew, start-to-valid latency
    fill(1);
    run_job(3);
    chk("k3_reads", 64'(rd_addrs.size()), 64'd3);
    chk("k3_addr0", 64'(rd_addrs[0]), 64'd0);
    chk("k3_addr1", 64'(rd_addrs[1]), 64'd1);
    chk("k3_addr2", 64'(rd_addrs[2]), 64'd2);
    chk("k3_skew3", 64'(first_b3_n - first_rd_n), 64'd4);
    chk("k3_latency", 64'(first_valid_n), 64'd13);

    // empty job right after a non-empty one
    run_job(0);
    chk("k0_reads", 64'(rd_addrs.size()), 64'd0);
    chk("k0_latency", 64'(first_valid_n), 64'd2);
    for (int i = 0; i < SIZE; i++)
      chk("k0_row", 64'(rec_rows[i]), 64'd0);

    // stalled drain
    fill(0);
    rdy_mode = 2;
    pat = 0;
    run_job(2);
    rdy_mode = 0;
    chk("stall_rows", 64'(rec_rows.size()), 64'(SIZE));
    for (int i = 0; i < SIZE; i++)
      chk("stall_order", 64'(rec_idx[i]), 64'(i));

    // start hammered while busy, then one more job
    d0 = dut_dones;
    @(posedge clk);
    #1;
    k_len = 9'd5;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      start = 1'(i % 2);
    end
    start = 1'b0;
    wait_done();
    run_job(3);
    chk("two_jobs", 64'(dut_dones - d0), 64'd2);

    // reset in the middle of feeding
    d0 = dut_dones;
    @(posedge clk);
    #1;
    k_len = 9'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_clr", 64'(arr_clr), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd", 64'(a_rd_en), 64'd0);
    chk("abort_left", 64'(arr_left), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_clr_drop", 64'(arr_clr), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(dut_dones - d0), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    // random jobs, including full depth and saturation
    for (int j = 0; j < 12; j++) begin
      fill(j[0]);
      rdy_mode = $urandom_range(0, 2);
      if (j == 3) kk = 256;
      else if (j == 5) kk = 300;
      else if (j == 8) kk = 0;
      else kk = $urandom_range(1, 12);
      run_job(kk);
      chk("rnd_rows", 64'(rec_rows.size()), 64'(SIZE));
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
